dmem_responder: RTL

//  Data-memory responder: the memory side of the pipeline's load/store interface.

---
 rtl/dmem_pkg.sv | 42 ++++
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared encodings, FSM state type and load-extension helper for
//             the data-memory responder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Right-align the addressed lane(s) of a word and extend to 32 bits.
  function automatic logic [31:0] extendLoad(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  size,
                                             input logic        uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (size)
      SIZE_B:  res = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SIZE_H:  res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
//  Module   : dmem_array
//  Purpose  : 32-bit word array, synchronous byte-enabled write, combinational
//             read. Contents are intentionally not reset.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = r_mem[addr];

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Memory side of the load/store interface: one request at a time,
//             programmable wait states, lane steering, extension, error flags.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  import dmem_pkg::*;

  state_t                r_state;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic                  r_reqReady;
  logic                  r_rspValid;
  logic [31:0]           r_rspRdata;
  logic                  r_rspErr;

  logic        w_err;
  logic        w_access;
  logic [3:0]  w_byteEn;
  logic [3:0]  w_wrEn;
  logic [31:0] w_wrData;
  logic [31:0] w_rdWord;

  always_comb begin
    w_err = (r_size == SIZE_X)
         || (r_size == SIZE_H && r_addr[0])
         || (r_size == SIZE_W && r_addr[1:0] != 2'b00)
         || ((r_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    case (r_size)
      SIZE_B: begin
        w_byteEn = 4'b0001 << r_addr[1:0];
        w_wrData = {4{r_wdata[7:0]}};
      end
      SIZE_H: begin
        w_byteEn = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wrData = {2{r_wdata[15:0]}};
      end
      default: begin
        w_byteEn = 4'b1111;
        w_wrData = r_wdata;
      end
    endcase
    w_access = (r_state == WAIT) && (r_cnt == '0);
    // An async reset during WAIT forces r_state to IDLE, so a pending store never commits.
    w_wrEn   = (w_access && r_we && !w_err) ? w_byteEn : 4'b0000;
  end

  dmem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (w_wrEn),
    .addr  (r_addr[ADDR_WIDTH+1:2]),
    .wdata (w_wrData),
    .rdata (w_rdWord)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_size     <= SIZE_B;
      r_uns      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_reqReady <= 1'b1;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspErr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_uns      <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_cnt      <= WAIT_CNT_W'(WAIT_CYCLES);
            r_reqReady <= 1'b0;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_rspRdata <= (w_err || r_we) ? 32'd0
                                          : extendLoad(w_rdWord, r_addr[1:0], r_size, r_uns);
            r_rspErr   <= w_err;
            r_rspValid <= 1'b1;
            r_state    <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
            r_rspErr   <= 1'b0;
            r_reqReady <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_reqReady <= 1'b1;
          r_rspValid <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_reqReady;
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;

endmodule

`default_nettype wire
